pipe_stage_latch: RTL and testbench

- Parametrised pipeline-stage latch carrying N operand channels, the program counter and the instruction between stages.
- Adds a valid/ready handshake, a two-entry skid buffer, stall back-pressure and flush (bubble insertion).
- Instantiated between every stage pair (F/D, D/X, X/M, M/W). Replaces fixed 32-bit always-enabled latches whose only control is a write enable.

---
 rtl/pipe_stage_latch.sv | 139 +++++++++++++
 tb/tb_pipe_stage_latch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_latch.sv
// Pipeline-stage latch: valid/ready handshake, optional two-entry skid buffer,
// flush (bubble insertion) and NOP gating of the presented instruction.
module pipe_stage_latch #(
    parameter int unsigned          DATA_WIDTH   = 32,
    parameter int unsigned          NUM_OPERANDS = 2,
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          INS_WIDTH    = 32,
    parameter logic [INS_WIDTH-1:0] NOP_INS      = '0,
    parameter bit                   SKID_EN      = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_OPERANDS*DATA_WIDTH-1:0] in_operands,
    input  logic [PC_WIDTH-1:0]                in_pc,
    input  logic [INS_WIDTH-1:0]               in_ins,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_OPERANDS*DATA_WIDTH-1:0] out_operands,
    output logic [PC_WIDTH-1:0]                out_pc,
    output logic [INS_WIDTH-1:0]               out_ins,
    output logic [1:0]                         occupancy
);

    localparam int unsigned OPS_WIDTH = NUM_OPERANDS * DATA_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [OPS_WIDTH-1:0] main_ops_q, skid_ops_q;
    logic [PC_WIDTH-1:0]  main_pc_q,  skid_pc_q;
    logic [INS_WIDTH-1:0] main_ins_q, skid_ins_q;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    // Skid mode decodes in_ready from the state flops only, so out_ready never
    // reaches it; single-entry mode trades that for a combinational pass-through.
    always_comb begin
        out_valid = reset_n & (state_q != EMPTY);
        if (SKID_EN)
            in_ready = reset_n & (state_q != TWO);
        else
            in_ready = reset_n & (~out_valid | out_ready);
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d      = TWO;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything held and arriving; a concurrent out_fire has
        // already been consumed downstream so nothing is lost there.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            main_ops_q <= '0;
            main_pc_q  <= '0;
            main_ins_q <= '0;
            skid_ops_q <= '0;
            skid_pc_q  <= '0;
            skid_ins_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_ops_q <= in_operands;
                main_pc_q  <= in_pc;
                main_ins_q <= in_ins;
            end else if (load_main_skid) begin
                main_ops_q <= skid_ops_q;
                main_pc_q  <= skid_pc_q;
                main_ins_q <= skid_ins_q;
            end
            if (load_skid_in) begin
                skid_ops_q <= in_operands;
                skid_pc_q  <= in_pc;
                skid_ins_q <= in_ins;
            end
        end
    end

    always_comb begin
        out_operands = out_valid ? main_ops_q : '0;
        out_pc       = out_valid ? main_pc_q  : '0;
        out_ins      = out_valid ? main_ins_q : NOP_INS;
        occupancy    = 2'd0;
        if (reset_n) begin
            unique case (state_q)
                ONE:     occupancy = 2'd1;
                TWO:     occupancy = 2'd2;
                default: occupancy = 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench: a skid-mode 3x16-bit instance and a single-entry default instance.
module tb_pipe_stage_latch;

    localparam logic [31:0] NOP_A = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [47:0] in_ops, out_ops;
    logic [31:0] in_pc, out_pc, in_ins, out_ins;
    logic [1:0]  occupancy;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_ops, b_out_ops;
    logic [31:0] b_in_pc, b_out_pc, b_in_ins, b_out_ins;
    logic [1:0]  b_occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pipe_stage_latch #(
        .DATA_WIDTH(16), .NUM_OPERANDS(3), .PC_WIDTH(32), .INS_WIDTH(32),
        .NOP_INS(NOP_A), .SKID_EN(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_operands(in_ops),
        .in_pc(in_pc), .in_ins(in_ins),
        .out_valid(out_valid), .out_ready(out_ready), .out_operands(out_ops),
        .out_pc(out_pc), .out_ins(out_ins), .occupancy(occupancy)
    );

    pipe_stage_latch #(.SKID_EN(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_operands(b_in_ops),
        .in_pc(b_in_pc), .in_ins(b_in_ins),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_operands(b_out_ops),
        .out_pc(b_out_pc), .out_ins(b_out_ins), .occupancy(b_occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_ins   = ins;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'hDEAD; in_ins = 32'h1234; in_ops = 48'hFFFF_FFFF_FFFF;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_ops = 64'h0; b_in_pc = 32'h0; b_in_ins = 32'h0;

        // Reset held two cycles with in_valid high
        tick(); tick();
        chk("rst_in_ready",  64'(in_ready),  0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_ins",   64'(out_ins),   64'(NOP_A));
        chk("rst_occ",       64'(occupancy), 0);
        chk("rst_out_pc",    64'(out_pc),    0);
        chk("rst_b_valid",   64'(b_out_valid), 0);

        reset_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 1);

        // Streaming with out_ready=1, first entry carries the 3-channel operands
        in_ops = 48'h3333_2222_1111;
        send(32'h100, 32'hA0);
        tick();
        chk("str0_pc",    64'(out_pc),    32'h100);
        chk("str0_ops",   64'(out_ops),   64'h3333_2222_1111);
        chk("str0_ins",   64'(out_ins),   32'hA0);
        chk("str0_valid", 64'(out_valid), 1);
        chk("str0_occ",   64'(occupancy), 1);
        in_ops = 48'h0006_0005_0004;
        send(32'h104, 32'hA4);
        tick();
        chk("str1_pc",    64'(out_pc),    32'h104);
        chk("str1_ops",   64'(out_ops),   64'h0006_0005_0004);
        chk("str1_valid", 64'(out_valid), 1);
        chk("str1_occ",   64'(occupancy), 1);
        send(32'h108, 32'hA8);
        tick();
        chk("str2_pc",    64'(out_pc),    32'h108);
        chk("str2_valid", 64'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 0);
        chk("drain_ops",   64'(out_ops),   0);
        chk("drain_ins",   64'(out_ins),   64'(NOP_A));
        chk("drain_occ",   64'(occupancy), 0);

        // Stall and skid
        out_ready = 1'b0;
        send(32'h10, 32'h11);
        tick();
        chk("skA_occ",      64'(occupancy), 1);
        chk("skA_in_ready", 64'(in_ready),  1);
        chk("skA_pc",       64'(out_pc),    32'h10);
        send(32'h14, 32'h15);
        tick();
        chk("skB_occ",      64'(occupancy), 2);
        chk("skB_in_ready", 64'(in_ready),  0);
        chk("skB_pc",       64'(out_pc),    32'h10);
        send(32'h99, 32'h99);
        tick();
        chk("stall_occ", 64'(occupancy), 2);
        chk("stall_pc",  64'(out_pc),    32'h10);
        chk("stall_ins", 64'(out_ins),   32'h11);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rel_in_ready_reg", 64'(in_ready), 0);
        chk("rel_pc_first",     64'(out_pc),   32'h10);
        tick();
        chk("rel_pc_second", 64'(out_pc),    32'h14);
        chk("rel_ins",       64'(out_ins),   32'h15);
        chk("rel_occ",       64'(occupancy), 1);
        chk("rel_in_ready",  64'(in_ready),  1);
        tick();
        chk("rel_empty_valid", 64'(out_valid), 0);

        // Flush from TWO with a concurrent entry C
        out_ready = 1'b0;
        send(32'h20, 32'h21); tick();
        send(32'h24, 32'h25); tick();
        chk("fl_pre_occ", 64'(occupancy), 2);
        send(32'h18, 32'h19); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ",   64'(occupancy), 0);
        chk("fl_ins",   64'(out_ins),   64'(NOP_A));
        chk("fl_pc",    64'(out_pc),    0);
        chk("fl_valid", 64'(out_valid), 0);
        tick();
        chk("fl_no_c", 64'(out_valid), 0);

        // Flush in ONE while an entry is accepted and one is delivered
        out_ready = 1'b1;
        send(32'h30, 32'h31); tick();
        send(32'h34, 32'h35); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_occ", 64'(occupancy), 0);
        tick();
        chk("fl1_gone", 64'(out_valid), 0);

        // Reset mid-operation discards both entries
        out_ready = 1'b0;
        send(32'h40, 32'h41); tick();
        send(32'h44, 32'h45); tick();
        reset_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_gated_valid", 64'(out_valid), 0);
        chk("rst_mid_gated_ins",   64'(out_ins),   64'(NOP_A));
        tick();
        reset_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_mid_occ",      64'(occupancy), 0);
        chk("rst_mid_in_ready", 64'(in_ready),  1);
        tick();
        chk("rst_mid_no_entry", 64'(out_valid), 0);

        // Single-entry instance: combinational in_ready
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_pc = 32'h50; b_in_ins = 32'h51;
        b_in_ops = 64'h0000_0002_0000_0001;
        #1;
        chk("b_empty_ready", 64'(b_in_ready), 1);
        tick();
        chk("b_held_pc",  64'(b_out_pc),  32'h50);
        chk("b_held_ops", 64'(b_out_ops), 64'h0000_0002_0000_0001);
        b_in_pc = 32'h54; b_in_ins = 32'h55;
        #1;
        chk("b_stall_ready", 64'(b_in_ready), 0);
        tick();
        chk("b_stall_pc", 64'(b_out_pc), 32'h50);
        b_out_ready = 1'b1;
        #1;
        chk("b_pass_ready", 64'(b_in_ready), 1);
        tick();
        chk("b_next_pc",    64'(b_out_pc),    32'h54);
        chk("b_next_valid", 64'(b_out_valid), 1);
        chk("b_next_occ",   64'(b_occupancy), 1);
        b_in_valid = 1'b0;
        tick();
        chk("b_drain_valid", 64'(b_out_valid), 0);
        chk("b_drain_ins",   64'(b_out_ins),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
